// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage with a 64x32 program memory.
//
// Holds the PC and a small instruction memory. A fetched word, the PC it
// came from and a valid flag are registered towards the IF/ID register.
// Fetch latency is one cycle. Addresses alias modulo 256 bytes (pc[7:2]).
//
// Priority each cycle: rst > redirect > stall > normal fetch.
//
// Build option: BRANCH_DELAY_SLOT_EN
//   undefined : a redirect squashes the word at the current PC
//               (instruction = 0, valid = 0, pc_out = current PC).
//   defined   : a redirect still fetches the word at the current PC as a
//               delay slot (valid = 1) while the target loads into the PC.
//
// Memory writes are independent of stall/redirect but never happen in a
// reset cycle. Reset does not clear memory contents.

module instr_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        imem_we,
    input  logic [5:0]  imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    logic [31:0] pc;
    logic [31:0] imem [0:63];

    logic [31:0] fetch_word;
    logic [31:0] pc_seq;
    logic [31:0] redirect_target;

    logic [31:0] pc_nxt;
    logic [31:0] instruction_nxt;
    logic [31:0] pc_out_nxt;
    logic        valid_nxt;

    // Low target bits are dropped: the PC is always word aligned.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Asynchronous read of the word at the current PC; the registered
    // write below lands after this read, giving read-before-write.
    assign fetch_word      = imem[pc[7:2]];
    assign pc_seq          = pc + 32'd4;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // pc_plus4 is derived from the registered pc_out, not from the PC.
    assign pc_plus4 = pc_out + 32'd4;

    // Next-value selection for the PC and the output register.
    always_comb begin
        pc_nxt          = pc;
        instruction_nxt = instruction;
        pc_out_nxt      = pc_out;
        valid_nxt       = valid;

        if (redirect) begin
            pc_nxt     = redirect_target;
            pc_out_nxt = pc;
`ifdef BRANCH_DELAY_SLOT_EN
            instruction_nxt = fetch_word;
            valid_nxt       = 1'b1;
`else
            instruction_nxt = 32'h0000_0000;
            valid_nxt       = 1'b0;
`endif
        end else if (!stall) begin
            pc_nxt          = pc_seq;
            instruction_nxt = fetch_word;
            pc_out_nxt      = pc;
            valid_nxt       = 1'b1;
        end
    end

    // PC and output register, synchronous reset to a bubble at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= 32'h0000_0000;
            instruction <= 32'h0000_0000;
            pc_out      <= 32'h0000_0000;
            valid       <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            instruction <= instruction_nxt;
            pc_out      <= pc_out_nxt;
            valid       <= valid_nxt;
        end
    end

    // Program-load port; suppressed during reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch.
// Directed scenarios compare against hand-derived constants; a randomized
// phase compares against a reference model of the fetch rules.

module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] mmem [0:63];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    logic        m_valid;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .instruction (instruction),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; the model applies the same inputs, then outputs are
    // sampled 1 time unit later. Inputs only change after this returns.
    task automatic tick();
        logic [31:0] word;
        @(posedge clk);
        word = mmem[m_pc[7:2]];
        if (rst) begin
            m_pc    = 0;
            m_instr = 0;
            m_pcout = 0;
            m_valid = 0;
        end else begin
            if (imem_we) mmem[imem_waddr] = imem_wdata;
            if (redirect) begin
                m_pcout = m_pc;
`ifdef BRANCH_DELAY_SLOT_EN
                m_instr = word;
                m_valid = 1;
`else
                m_instr = 0;
                m_valid = 0;
`endif
                m_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (!stall) begin
                m_instr = word;
                m_pcout = m_pc;
                m_valid = 1;
                m_pc    = m_pc + 4;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; redirect = 0; redirect_pc = 0;
        imem_we = 0; imem_waddr = 0; imem_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic load_program();
        do_reset();
        stall = 1;
        for (int i = 0; i < 64; i++) begin
            imem_we    = 1;
            imem_waddr = 6'(i);
            case (i)
                0: imem_wdata = 32'h2008_0005;
                1: imem_wdata = 32'h2009_0007;
                2: imem_wdata = 32'h0109_5020;
                default: imem_wdata = $urandom;
            endcase
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; stall = 1; redirect = 1; redirect_pc = 32'h0000_0084;
        imem_we = 1; imem_waddr = 6'd1; imem_wdata = 32'hFFFF_0000;
        tick();
        checks++;
        if ({valid, pc_out, instruction} !== {1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%0b pc_out=%h instr=%h, need 0/0/0",
                     valid, pc_out, instruction);
        end
        checks++;
        if (pc_plus4 !== 32'h4) begin
            failures++;
            $display("FAIL reset_pc_plus4: got %h need 00000004", pc_plus4);
        end
        idle_inputs();
    endtask

    task automatic test_basic_fetch();
        logic [31:0] exp_w [0:2];
        exp_w[0] = 32'h2008_0005;
        exp_w[1] = 32'h2009_0007;   // reset-cycle write to index 1 must not land
        exp_w[2] = 32'h0109_5020;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid, pc_out, instruction, pc_plus4} !==
                {1'b1, 32'(i * 4), exp_w[i], 32'(i * 4 + 4)}) begin
                failures++;
                $display("FAIL basic_fetch_%0d: got valid=%0b pc_out=%h instr=%h pc4=%h, need 1/%h/%h/%h",
                         i, valid, pc_out, instruction, pc_plus4, 32'(i * 4), exp_w[i], 32'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid, pc_out, instruction} !== {1'b1, 32'h4, 32'h2009_0007}) begin
                failures++;
                $display("FAIL stall_hold_%0d: got valid=%0b pc_out=%h instr=%h, need 1/00000004/20090007",
                         i, valid, pc_out, instruction);
            end
        end
        stall = 0;
        tick();
        checks++;
        if ({valid, pc_out, instruction} !== {1'b1, 32'h8, 32'h0109_5020}) begin
            failures++;
            $display("FAIL stall_release: got valid=%0b pc_out=%h instr=%h, need 1/00000008/01095020",
                     valid, pc_out, instruction);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] w10, w20;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        w10 = mmem[4];
        w20 = mmem[8];
        redirect = 1; redirect_pc = 32'h0000_0023;
        tick();
        redirect = 0;
        checks++;
`ifdef BRANCH_DELAY_SLOT_EN
        if ({valid, pc_out, instruction} !== {1'b1, 32'h10, w10}) begin
            failures++;
            $display("FAIL redirect_slot: got valid=%0b pc_out=%h instr=%h, need 1/00000010/%h",
                     valid, pc_out, instruction, w10);
        end
`else
        if ({valid, pc_out, instruction} !== {1'b0, 32'h10, 32'h0}) begin
            failures++;
            $display("FAIL redirect_squash: got valid=%0b pc_out=%h instr=%h, need 0/00000010/00000000",
                     valid, pc_out, instruction);
        end
`endif
        tick();
        checks++;
        if ({valid, pc_out, instruction} !== {1'b1, 32'h20, w20}) begin
            failures++;
            $display("FAIL redirect_target: got valid=%0b pc_out=%h instr=%h, need 1/00000020/%h",
                     valid, pc_out, instruction, w20);
        end
    endtask

    task automatic test_redirect_stall();
        redirect = 1; stall = 1; redirect_pc = 32'h0000_0040;
        tick();
        redirect = 0; stall = 0;
        checks++;
        if (pc_out !== 32'h24) begin
            failures++;
            $display("FAIL redirect_stall_mid: got pc_out=%h need 00000024", pc_out);
        end
        tick();
        checks++;
        if ({valid, pc_out, instruction} !== {1'b1, 32'h40, mmem[16]}) begin
            failures++;
            $display("FAIL redirect_stall_target: got valid=%0b pc_out=%h instr=%h, need 1/00000040/%h",
                     valid, pc_out, instruction, mmem[16]);
        end
    endtask

    task automatic test_reset_redirect();
        rst = 1; redirect = 1; redirect_pc = 32'h0000_0080;
        imem_we = 1; imem_waddr = 6'd0; imem_wdata = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        checks++;
        if ({valid, pc_out, instruction} !== {1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_redirect_outputs: got valid=%0b pc_out=%h instr=%h, need 0/0/0",
                     valid, pc_out, instruction);
        end
        tick();
        checks++;
        if ({valid, pc_out, instruction} !== {1'b1, 32'h0, 32'h2008_0005}) begin
            failures++;
            $display("FAIL reset_redirect_next: got valid=%0b pc_out=%h instr=%h, need 1/00000000/20080005",
                     valid, pc_out, instruction);
        end
    endtask

    task automatic test_read_before_write();
        do_reset();
        imem_we = 1; imem_waddr = 6'd0; imem_wdata = 32'hCAFE_0001;
        tick();
        imem_we = 0;
        checks++;
        if ({valid, pc_out, instruction} !== {1'b1, 32'h0, 32'h2008_0005}) begin
            failures++;
            $display("FAIL rbw_old_word: got valid=%0b pc_out=%h instr=%h, need 1/00000000/20080005",
                     valid, pc_out, instruction);
        end
        redirect = 1; redirect_pc = 32'h0;
        tick();
        redirect = 0;
        tick();
        checks++;
        if ({valid, pc_out, instruction} !== {1'b1, 32'h0, 32'hCAFE_0001}) begin
            failures++;
            $display("FAIL rbw_new_word: got valid=%0b pc_out=%h instr=%h, need 1/00000000/cafe0001",
                     valid, pc_out, instruction);
        end
    endtask

    task automatic test_wrap();
        redirect = 1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 0;
        tick();
        checks++;
        if ({valid, pc_out, instruction, pc_plus4} !== {1'b1, 32'hFFFF_FFFC, mmem[63], 32'h0}) begin
            failures++;
            $display("FAIL wrap_top: got valid=%0b pc_out=%h instr=%h pc4=%h, need 1/fffffffc/%h/00000000",
                     valid, pc_out, instruction, pc_plus4, mmem[63]);
        end
        tick();
        checks++;
        if ({valid, pc_out, instruction} !== {1'b1, 32'h0, mmem[0]}) begin
            failures++;
            $display("FAIL wrap_zero: got valid=%0b pc_out=%h instr=%h, need 1/00000000/%h",
                     valid, pc_out, instruction, mmem[0]);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 19) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = $urandom;
            imem_we     = ($urandom_range(0, 3) == 0);
            imem_waddr  = 6'($urandom_range(0, 63));
            imem_wdata  = $urandom;
            tick();
            checks++;
            if ({valid, pc_out, instruction, pc_plus4} !==
                {m_valid, m_pcout, m_instr, m_pcout + 32'd4}) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d: got valid=%0b pc_out=%h instr=%h pc4=%h, need %0b/%h/%h/%h",
                             n, valid, pc_out, instruction, pc_plus4,
                             m_valid, m_pcout, m_instr, m_pcout + 32'd4);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pcout = 0; m_valid = 0;
        for (int i = 0; i < 64; i++) mmem[i] = 32'h0;
        idle_inputs();
        load_program();
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_reset_redirect();
        test_read_before_write();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall  input  1  hazard hold; freezes PC and all outputs.
REQ-005 redirect  input  1  taken branch/jump request.
REQ-006 redirect_pc  input  32  byte target of the redirect.
REQ-007 imem_we  input  1  program-load write enable.
REQ-008 imem_waddr  input  6  program-load word index.
REQ-009 imem_wdata  input  32  program-load word.
REQ-010 instruction  output  32  registered fetched word, fed to the IF/ID register.
REQ-011 pc_out  output  32  byte address of the word in instruction.
REQ-012 pc_plus4  output  32  pc_out + 4, combinational from pc_out.
REQ-013 valid  output  1  instruction holds a real fetched word; 0 means bubble/NOP.

Function
REQ-014 The block SHALL hold a 32-bit PC register and a 64x32 instruction memory indexed by pc[7:2].
- Addresses at or above 0x100 alias modulo 256 bytes.
REQ-015 Each cycle SHALL apply this priority: rst > redirect > stall > normal fetch.
REQ-016 On a normal fetch, the following SHALL update at the next edge:
- instruction <= imem[pc[7:2]]
- pc_out <= pc
- valid <= 1
- pc <= pc + 4
REQ-017 Fetch latency SHALL be one cycle: a PC value appears on pc_out together with its word at the edge after it was the current PC.
REQ-018 When stall=1 and redirect=0, the PC, instruction, pc_out and valid SHALL hold their values.
REQ-019 On redirect, pc SHALL load {redirect_pc[31:2], 2'b00}; bits [1:0] are discarded.
REQ-020 A redirect SHALL be accepted even when stall=1 in the same cycle.
REQ-021 The squash behaviour on redirect SHALL follow REQ-030/031.
REQ-022 The PC increment SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-023 imem writes SHALL occur on any non-reset edge with imem_we=1, independent of stall and redirect.
REQ-024 A same-cycle read and write to one index SHALL return the old word (read-before-write).

Reset
REQ-025 With rst=1 at an edge, the following SHALL apply:
- pc = 0
- instruction = 0x00000000
- pc_out = 0
- valid = 0
REQ-026 Reset SHALL override simultaneous stall, redirect and imem_we; no memory write occurs in a reset cycle.
REQ-027 Reset SHALL NOT clear memory contents.
REQ-028 The first fetch after rst deasserts SHALL be from address 0x00000000.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending target.

Configuration
REQ-030 Without BRANCH_DELAY_SLOT_EN, a redirect cycle SHALL do the following:
- load instruction = 0x00000000 and valid = 0, squashing the word at the current PC;
- pc_out SHALL take the current PC.
REQ-031 With BRANCH_DELAY_SLOT_EN defined, a redirect cycle SHALL do the following:
- fetch normally from the current PC (delay slot: valid=1, instruction=imem[pc[7:2]], pc_out=pc);
- load the redirect target into pc in the same cycle.

Verification
REQ-032 Load words 0x20080005, 0x20090007, 0x01095020 at indices 0-2, then release rst. Required: over three cycles, pc_out = 0, 4, 8 with matching words and valid=1.
REQ-033 Hold stall=1 for 3 cycles after pc_out=4. Required: pc_out=4 and its word persist; after release, the next pc_out=8.
REQ-034 Redirect to 0x00000023 when pc=0x10. Required: the next fetch is from 0x20. Without the macro, the intervening output is valid=0 with a zero word. With the macro, it is the word at 0x10 with valid=1.
REQ-035 Assert redirect=1 and stall=1 together with target 0x40. Required: the redirect wins and the next valid fetch is from 0x40.
REQ-036 Assert rst for one cycle during a redirect to 0x80. Required: all outputs go to 0 and the next fetch is from 0x00. Rewriting index 0 in the same cycle as a fetch of index 0 returns the old word.
